muldiv_seq_ctrl: RTL

- Multi-cycle sequencer for unsigned 32x32 multiply (shift-add) and 32/32 divide (restoring).
- Owns no adder. It drives the A/B/SnA inputs of one external RC_ADD_SUB_32 instance each cycle and consumes its Y/CO outputs.
- Sits beside the ALU. The core issues MUL/DIV through a START/DONE handshake so the ALU's adder/subtractor datapath is reused rather than duplicated.

---
 rtl/muldiv_seq_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq_ctrl.sv
// muldiv_seq_ctrl
// Multi-cycle sequencer for unsigned WIDTH x WIDTH multiply (shift-add) and
// WIDTH / WIDTH divide (restoring). It owns no adder. Each cycle it drives
// one external add/sub unit (the ALU's RC_ADD_SUB instance) and consumes
// that unit's sum and carry. A START/DONE handshake lets the core share the
// ALU datapath instead of duplicating it.
//
// Ports:
//   i_clk       system clock, rising edge
//   i_rst       asynchronous active-high reset
//   i_start     request pulse, sampled only in IDLE
//   i_mode      0 = multiply, 1 = divide (latched with i_start)
//   i_op_a      multiplicand / dividend (latched with i_start)
//   i_op_b      multiplier / divisor (latched with i_start)
//   o_busy      high while iterating (CALC)
//   o_done      one-cycle completion pulse (FIN)
//   o_res_hi    product upper half, or remainder
//   o_res_lo    product lower half, or quotient
//   o_add_a     external adder operand A
//   o_add_b     external adder operand B
//   o_add_sn_a  external adder mode, 0 = add, 1 = subtract
//   i_add_y     external adder result
//   i_add_co    external adder carry out
module muldiv_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_res_hi,
  output logic [WIDTH-1:0] o_res_lo,
  output logic [WIDTH-1:0] o_add_a,
  output logic [WIDTH-1:0] o_add_b,
  output logic             o_add_sn_a,
  input  logic [WIDTH-1:0] i_add_y,
  input  logic             i_add_co
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_m;
  logic             r_md;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_sh;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;
  logic             w_last;

  // Divide works on the partial remainder shifted left by one with the next
  // dividend bit pulled in; the bit shifted out of HI is kept separately
  // because when it is set the shifted value is certainly >= the divisor.
  assign w_sh   = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  assign o_busy   = (r_state == CALC);
  assign o_done   = (r_state == FIN);
  assign o_res_hi = r_hi;
  assign o_res_lo = r_lo;

  // State register. Reset abandons any operation in flight, so no DONE
  // can follow a mid-CALC reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state, adder drive and per-iteration update of HI/LO. The adder
  // inputs are only non-zero during CALC so the shared unit sees a quiet
  // bus whenever the sequencer is not using it.
  always_comb begin
    w_next     = r_state;
    o_add_a    = '0;
    o_add_b    = '0;
    o_add_sn_a = 1'b0;
    w_hi_nxt   = r_hi;
    w_lo_nxt   = r_lo;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_next = CALC;
        end
      end
      CALC: begin
        if (w_last) begin
          w_next = FIN;
        end
        if (r_md) begin
          o_add_a    = w_sh;
          o_add_b    = r_m;
          o_add_sn_a = 1'b1;
          // Carry out of a subtract means no borrow, i.e. sh >= M.
          if (r_hi[WIDTH-1] | i_add_co) begin
            w_hi_nxt = i_add_y;
            w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
          end else begin
            w_hi_nxt = w_sh;
            w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
          end
        end else begin
          o_add_a = r_hi;
          o_add_b = r_m;
          // The carry becomes the new top bit so the full 2W product survives.
          if (r_lo[0]) begin
            w_hi_nxt = {i_add_co, i_add_y[WIDTH-1:1]};
            w_lo_nxt = {i_add_y[0], r_lo[WIDTH-1:1]};
          end else begin
            w_hi_nxt = {1'b0, r_hi[WIDTH-1:1]};
            w_lo_nxt = {r_hi[0], r_lo[WIDTH-1:1]};
          end
        end
      end
      FIN: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Operand latch and working registers. Results hold after FIN until the
  // next accepted START reloads them.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_m   <= '0;
      r_md  <= 1'b0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_md  <= i_mode;
            r_m   <= i_op_b;
            r_hi  <= '0;
            r_lo  <= i_op_a;
            r_cnt <= '0;
          end
        end
        CALC: begin
          r_hi  <= w_hi_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
